// File: rtl/iterative_incdec.sv
// Multi-cycle N-bit incrementor/decrementor: walks the operand K bits per clock, LSB chunk first,
// carrying (or borrowing) between chunks through a register, with optional early termination.
//
// state | meaning
// IDLE  | waiting for start; s, carry_out and cycles hold the last result
// RUN   | one chunk processed per edge, busy=1
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module iterative_incdec #(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode,
    input  logic                         early_exit_en,
    input  logic [N-1:0]                 a,
    output logic                         busy,
    output logic                         done,
    output logic [N-1:0]                 s,
    output logic                         carry_out,
    output logic [$clog2(N/K+1)-1:0]     cycles
);

    localparam int M  = N / K;
    localparam int CW = $clog2(M + 1);
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [N-1:0]   work;
    logic           run_carry;
    logic [IW-1:0]  idx;
    logic [CW-1:0]  cnt;
    logic           mode_q;
    logic           ee_q;

    logic [K-1:0]   chunk;
    logic [K-1:0]   chunk_nxt;
    logic           carry_nxt;
    logic [N-1:0]   work_nxt;
    logic           last;

    always_comb begin
        chunk = '0;
        for (int j = 0; j < M; j++) begin
            if (idx == IW'(j)) chunk = work[j*K +: K];
        end
        chunk_nxt = mode_q ? (chunk - K'(run_carry)) : (chunk + K'(run_carry));
        carry_nxt = run_carry & (mode_q ? (chunk == '0) : (chunk == '1));
        work_nxt = work;
        for (int j = 0; j < M; j++) begin
            if (idx == IW'(j)) work_nxt[j*K +: K] = chunk_nxt;
        end
        // Once the carry dies every higher chunk would pass through unchanged anyway.
        last = (idx == IW'(M - 1)) || (ee_q && !carry_nxt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            work      <= '0;
            run_carry <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            ee_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s         <= '0;
            carry_out <= 1'b0;
            cycles    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        work      <= a;
                        mode_q    <= mode;
                        ee_q      <= early_exit_en;
                        run_carry <= 1'b1;
                        idx       <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work      <= work_nxt;
                    run_carry <= carry_nxt;
                    cnt       <= cnt + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        s         <= work_nxt;
                        carry_out <= carry_nxt;
                        cycles    <= cnt + CW'(1);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_incdec.sv
// Scoreboard bench for iterative_incdec: three builds (K=2, K=1, K=8, N=8) share stimulus,
// expected results come from plain a+-1 arithmetic and trailing-bit counting.
module tb_iterative_incdec;

    typedef struct {
        logic [7:0] s;
        logic       co;
        int         cyc;
        int         issue;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start2, start1, start8;
    logic       mode;
    logic       early_exit_en;
    logic [7:0] a;

    logic       busy2, busy1, busy8;
    logic       done2, done1, done8;
    logic [7:0] s2, s1, s8;
    logic       co2, co1, co8;
    logic [2:0] cycles2;
    logic [3:0] cycles1;
    logic [0:0] cycles8;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    exp_t q2[$];
    exp_t q1[$];
    exp_t q8[$];
    logic [2:0] prev_done = '0;
    int   last_done[3];

    iterative_incdec #(.N(8), .K(2)) u_k2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode), .early_exit_en(early_exit_en),
        .a(a), .busy(busy2), .done(done2), .s(s2), .carry_out(co2), .cycles(cycles2));
    iterative_incdec #(.N(8), .K(1)) u_k1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode), .early_exit_en(early_exit_en),
        .a(a), .busy(busy1), .done(done1), .s(s1), .carry_out(co1), .cycles(cycles1));
    iterative_incdec #(.N(8), .K(8)) u_k8 (
        .clk(clk), .reset(reset), .start(start8), .mode(mode), .early_exit_en(early_exit_en),
        .a(a), .busy(busy8), .done(done8), .s(s8), .carry_out(co8), .cycles(cycles8));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int k, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s (K=%0d): got 0x%0h, expected 0x%0h", name, k, act, req);
    endtask

    function automatic int kval(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 8;
    endfunction

    // Reference: the operation stops at the first chunk whose trailing run of
    // carry-propagating bits (ones for inc, zeros for dec) ends.
    function automatic exp_t model(input logic md, input logic ee, input logic [7:0] av, input int k);
        exp_t e;
        int   t = 0;
        int   m = 8 / k;
        while (t < 8 && av[t] == !md) t++;
        e.s     = md ? av - 8'd1 : av + 8'd1;
        e.co    = (t == 8);
        e.cyc   = ee ? (((t / k) + 1 < m) ? (t / k) + 1 : m) : m;
        e.issue = cyc;
        return e;
    endfunction

    task automatic push(input int i, input exp_t e);
        case (i)
            0: q2.push_back(e);
            1: q1.push_back(e);
            default: q8.push_back(e);
        endcase
    endtask

    task automatic pop(input int i, output bit found, output exp_t e);
        found = 1'b0;
        e = '{s: 8'h00, co: 1'b0, cyc: 0, issue: 0};
        case (i)
            0: if (q2.size() > 0) begin e = q2.pop_front(); found = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); found = 1'b1; end
            default: if (q8.size() > 0) begin e = q8.pop_front(); found = 1'b1; end
        endcase
    endtask

    function automatic logic get_busy(input int i);
        return (i == 0) ? busy2 : (i == 1) ? busy1 : busy8;
    endfunction

    function automatic logic get_done(input int i);
        return (i == 0) ? done2 : (i == 1) ? done1 : done8;
    endfunction

    task automatic set_start(input int i, input logic v);
        case (i)
            0: start2 = v;
            1: start1 = v;
            default: start8 = v;
        endcase
    endtask

    task automatic mon(input int i, input logic dn, input logic bsy, input logic [7:0] so,
                       input logic co, input int cy);
        exp_t e;
        bit   found;
        int   iss;
        if (dn) begin
            chk("done_width", kval(i), int'(prev_done[i]), 0);
            chk("busy_at_done", kval(i), int'(bsy), 0);
            pop(i, found, e);
            if (!found) begin
                chk("unexpected_done", kval(i), 1, 0);
            end else begin
                chk("s", kval(i), int'(so), int'(e.s));
                chk("carry_out", kval(i), int'(co), int'(e.co));
                chk("cycles", kval(i), cy, e.cyc);
                iss = (e.issue < 0) ? last_done[i] : e.issue;
                chk("latency", kval(i), cyc - iss, e.cyc + 1);
            end
            last_done[i] = cyc;
        end
        prev_done[i] = dn;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_done = '0;
            end else begin
                mon(0, done2, busy2, s2, co2, int'(cycles2));
                mon(1, done1, busy1, s1, co1, int'(cycles1));
                mon(2, done8, busy8, s8, co8, int'(cycles8));
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 2, int'({busy2, busy1, busy8}), 0);
        chk({tag, "_done"}, 2, int'({done2, done1, done8}), 0);
        chk({tag, "_s"}, 2, int'({s2, s1, s8}), 0);
        chk({tag, "_carry_out"}, 2, int'({co2, co1, co8}), 0);
        chk({tag, "_cycles"}, 2, int'({cycles2, cycles1, cycles8}), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy2 | busy1 | busy8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 0, n, 0);
    endtask

    task automatic issue(input logic md, input logic ee, input logic [7:0] av);
        wait_idle();
        mode = md;
        early_exit_en = ee;
        a = av;
        for (int i = 0; i < 3; i++) begin
            push(i, model(md, ee, av, kval(i)));
            set_start(i, 1'b1);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) set_start(i, 1'b0);
    endtask

    initial begin : stimulus
        bit   got[3];
        bit   dropped[3];
        int   n;
        exp_t e;
        reset = 1'b0;
        start2 = 1'b0;
        start1 = 1'b0;
        start8 = 1'b0;
        mode = 1'b0;
        early_exit_en = 1'b0;
        a = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        issue(1'b0, 1'b0, 8'h00);
        issue(1'b0, 1'b1, 8'hFF);
        issue(1'b0, 1'b1, 8'h03);
        issue(1'b1, 1'b1, 8'h10);
        issue(1'b1, 1'b1, 8'h00);
        issue(1'b1, 1'b0, 8'hA5);

        // start held high through RUN: ignored while busy, accepted again in DONE
        wait_idle();
        mode = 1'b0;
        early_exit_en = 1'b1;
        a = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            push(i, model(1'b0, 1'b1, 8'h0F, kval(i)));
            e = model(1'b0, 1'b1, 8'h0F, kval(i));
            e.issue = -1;
            push(i, e);
            set_start(i, 1'b1);
            got[i] = 1'b0;
            dropped[i] = 1'b0;
        end
        n = 0;
        while (!(dropped[0] && dropped[1] && dropped[2]) && n < 100) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 3; i++) begin
                if (!dropped[i]) begin
                    if (got[i] && get_busy(i)) begin
                        set_start(i, 1'b0);
                        dropped[i] = 1'b1;
                    end else if (get_done(i)) begin
                        got[i] = 1'b1;
                    end
                end
            end
        end
        if (n >= 100) chk("b2b_timeout", 0, n, 0);
        for (int i = 0; i < 3; i++) set_start(i, 1'b0);

        // reset pulse while the K=2 and K=1 builds sit at chunk index 2
        wait_idle();
        mode = 1'b0;
        early_exit_en = 1'b0;
        a = 8'h37;
        push(2, model(1'b0, 1'b0, 8'h37, 8));
        for (int i = 0; i < 3; i++) set_start(i, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) set_start(i, 1'b0);
        repeat (2) @(negedge clk);
        chk("mid_run_busy", 2, int'(busy2), 1);
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        q2.delete();
        q1.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(1'b0, 1'b1, 8'h37);

        for (int v = 0; v < 256; v++) begin
            for (int md = 0; md < 2; md++) begin
                for (int ee = 0; ee < 2; ee++) begin
                    issue(md[0], ee[0], v[7:0]);
                end
            end
        end

        for (int r = 0; r < 300; r++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        n = 0;
        while ((q2.size() + q1.size() + q8.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("drain", 0, q2.size() + q1.size() + q8.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
